mp_add_seq: RTL

//  Multi-precision add/subtract sequencer built around one shared Con_sa_64 adder.

---
 rtl/mp_add_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS x 64-bit operands through one
// shared 64-bit conditional-sum adder, one word per cycle, chaining carries upward.

module Con_sa_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  localparam int BLK = 8;
  localparam int NB  = 64 / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in outcomes; the incoming carry only steers muxes.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;

    assign r0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign r1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + (BLK+1)'(1);

    assign sum[i*BLK +: BLK] = carry[i] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign carry[i+1]        = carry[i] ? r1[BLK]     : r0[BLK];
  end

  assign cout = carry[NB];

endmodule

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*64-1:0]   in_a,
  input  logic [WORDS*64-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*64-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int W     = WORDS * 64;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     result;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             step;
  logic             last;
  logic [63:0]      a_word;
  logic [63:0]      b_word;
  logic [63:0]      add_sum;
  logic             add_cout;

  assign a_word = op_a[idx*64 +: 64];
  assign b_word = op_b[idx*64 +: 64];
  assign last   = (idx == LAST_IDX);

  Con_sa_64 u_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the operand and result registers are plain flops (no RAM), so clearing them
  // on reset is cheap and guarantees a reset pulse wipes any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= in_a;
        op_b  <= in_sub ? ~in_b : in_b;
        idx   <= '0;
        carry <= in_sub;
      end
      if (step) begin
        result[idx*64 +: 64] <= add_sum;
        carry                <= add_cout;
        if (last) begin
          cout_q <= add_cout;
          // Signed overflow judged on the post-inversion operand, so one rule covers add and sub.
          ovf_q  <= (a_word[63] == b_word[63]) && (add_sum[63] != a_word[63]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign out_sum  = result;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_cout) && $stable(out_ovf)));

  a_no_accept_busy: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> !in_ready);

endmodule
